// File: rtl/if_fetch_stage_pkg.sv
// Shared IF-stage types and constants.
// Imported by the fetch stage and its helpers.
package if_fetch_stage_pkg;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP    = 32'd0;
  localparam logic [31:0] PC_INC = 32'd4;

endpackage

// File: rtl/if_wait_counter.sv
// Counts consecutive imem wait cycles.
// Raises a sticky timeout flag at MAX_WAIT.
module if_wait_counter #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic req,
  input  logic ready,
  output logic fetch_error
);

  localparam int W = $clog2(MAX_WAIT + 1);
  localparam logic [W-1:0] CMAX = W'(MAX_WAIT);

  logic [W-1:0] wait_cnt;
  logic [W-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = wait_cnt;
    if (ready)
      cnt_nxt = '0;
    else if (req && wait_cnt != CMAX)
      cnt_nxt = wait_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt    <= '0;
      fetch_error <= 1'b0;
    end else begin
      wait_cnt <= cnt_nxt;
      if (cnt_nxt == CMAX)
        fetch_error <= 1'b1;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: PC, redirects,
// freeze hold buffer and in-flight discard.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] instruction,
  output logic [31:0] pc_plus_4,
  output logic        if_valid,
  output logic        IF_Flush,
  output logic        fetch_error
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  tgt;
  logic [31:0]  hold_instr;
  logic [31:0]  hold_pc4;

  logic        redirect;
  logic [31:0] target;
  logic [31:0] pc4;

  assign redirect = jump | branch_taken;
  assign target   = jump ? jump_target
                         : branch_target;
  assign pc4      = pc + PC_INC;
  assign IF_Flush = redirect;
  assign imem_req = (state != HOLD);
  assign imem_addr = pc;

  always_comb begin
    if_valid    = 1'b0;
    instruction = NOP;
    pc_plus_4   = 32'd0;
    unique case (state)
      FETCH: begin
        if (imem_ready && !redirect) begin
          if_valid    = 1'b1;
          instruction = imem_rdata;
          pc_plus_4   = pc4;
        end
      end
      HOLD: begin
        if (!redirect) begin
          if_valid    = 1'b1;
          instruction = hold_instr;
          pc_plus_4   = hold_pc4;
        end
      end
      default: begin
        if_valid = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      tgt        <= 32'd0;
      hold_instr <= 32'd0;
      hold_pc4   <= 32'd0;
    end else begin
      unique case (state)
        FETCH: begin
          if (redirect) begin
            if (imem_ready) begin
              pc <= target;
            end else begin
              tgt   <= target;
              state <= DISCARD;
            end
          end else if (imem_ready) begin
            pc <= pc4;
            if (freeze) begin
              hold_instr <= imem_rdata;
              hold_pc4   <= pc4;
              state      <= HOLD;
            end
          end
        end
        HOLD: begin
          if (redirect) begin
            pc    <= target;
            state <= FETCH;
          end else if (!freeze) begin
            state <= FETCH;
          end
        end
        DISCARD: begin
          // newest redirect wins over the stored one
          if (redirect) begin
            tgt <= target;
            if (imem_ready) begin
              pc    <= target;
              state <= FETCH;
            end
          end else if (imem_ready) begin
            pc    <= tgt;
            state <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

  if_wait_counter #(
    .MAX_WAIT(MAX_WAIT)
  ) u_wait (
    .clk        (clk),
    .reset      (reset),
    .req        (imem_req),
    .ready      (imem_ready),
    .fetch_error(fetch_error)
  );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage.
// Vector table plus timeout/reset/wrap sequences.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  logic        imem_req, w_req;
  logic [31:0] imem_addr, w_addr;
  logic [31:0] instruction, w_instr;
  logic [31:0] pc_plus_4, w_pc4;
  logic        if_valid, w_valid;
  logic        IF_Flush, w_flush;
  logic        fetch_error, w_err;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  if_fetch_stage dut (
    .clk          (clk),
    .reset        (reset),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .jump         (jump),
    .jump_target  (jump_target),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .instruction  (instruction),
    .pc_plus_4    (pc_plus_4),
    .if_valid     (if_valid),
    .IF_Flush     (IF_Flush),
    .fetch_error  (fetch_error)
  );

  if_fetch_stage #(
    .RESET_PC(32'hFFFF_FFFC)
  ) u_wrap (
    .clk          (clk),
    .reset        (reset),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .jump         (jump),
    .jump_target  (jump_target),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .imem_req     (w_req),
    .imem_addr    (w_addr),
    .instruction  (w_instr),
    .pc_plus_4    (w_pc4),
    .if_valid     (w_valid),
    .IF_Flush     (w_flush),
    .fetch_error  (w_err)
  );

  typedef struct {
    logic        frz;
    logic        br;
    logic [31:0] bt;
    logic        jp;
    logic [31:0] jt;
    logic        rdy;
    logic [31:0] rd;
    logic        ereq;
    logic [31:0] eaddr;
    logic        evalid;
    logic [31:0] einstr;
    logic [31:0] epc4;
    logic        eflush;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(
    input logic frz, input logic br,
    input logic [31:0] bt, input logic jp,
    input logic [31:0] jt, input logic rdy,
    input logic [31:0] rd, input logic ereq,
    input logic [31:0] eaddr,
    input logic evalid,
    input logic [31:0] einstr,
    input logic [31:0] epc4,
    input logic eflush);
    vec_t v;
    v.frz = frz; v.br = br; v.bt = bt;
    v.jp = jp; v.jt = jt; v.rdy = rdy;
    v.rd = rd; v.ereq = ereq;
    v.eaddr = eaddr; v.evalid = evalid;
    v.einstr = einstr; v.epc4 = epc4;
    v.eflush = eflush;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  task automatic idle();
    freeze = 0; branch_taken = 0;
    jump = 0; branch_target = 0;
    jump_target = 0; imem_ready = 0;
    imem_rdata = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    reset = 1;
    tick();
    tick();
    reset = 0;
    #3;
    chk("rst_req", 32'(imem_req), 1);
    chk("rst_addr", imem_addr, 0);
    chk("rst_valid", 32'(if_valid), 0);
    chk("rst_err", 32'(fetch_error), 0);
    chk("rst_waddr", w_addr, 32'hFFFF_FFFC);

    //     frz br bt      jp jt      rdy rd
    //     req addr valid instr pc4 flush
    vq.push_back(mk(0,0,0,0,0,1,32'hA0,
      1,32'h0,1,32'hA0,32'h4,0));
    vq.push_back(mk(0,0,0,0,0,1,32'hA1,
      1,32'h4,1,32'hA1,32'h8,0));
    vq.push_back(mk(1,0,0,0,0,1,32'h2002000A,
      1,32'h8,1,32'h2002000A,32'hC,0));
    vq.push_back(mk(1,0,0,0,0,0,32'h0,
      0,32'hC,1,32'h2002000A,32'hC,0));
    vq.push_back(mk(0,0,0,0,0,0,32'h0,
      0,32'hC,1,32'h2002000A,32'hC,0));
    vq.push_back(mk(0,0,0,0,0,1,32'hA3,
      1,32'hC,1,32'hA3,32'h10,0));
    vq.push_back(mk(0,0,0,1,32'h40,0,32'h0,
      1,32'h10,0,32'h0,32'h0,1));
    vq.push_back(mk(0,0,0,0,0,0,32'h0,
      1,32'h10,0,32'h0,32'h0,0));
    vq.push_back(mk(0,0,0,0,0,1,32'hDEAD,
      1,32'h10,0,32'h0,32'h0,0));
    vq.push_back(mk(0,0,0,0,0,1,32'hB0,
      1,32'h40,1,32'hB0,32'h44,0));
    vq.push_back(mk(0,1,32'h100,1,32'h80,1,
      32'hBAD,1,32'h44,0,32'h0,32'h0,1));
    vq.push_back(mk(0,0,0,0,0,1,32'hC0,
      1,32'h80,1,32'hC0,32'h84,0));
    vq.push_back(mk(0,1,32'h200,0,0,0,32'h0,
      1,32'h84,0,32'h0,32'h0,1));
    vq.push_back(mk(0,0,0,1,32'h300,0,32'h0,
      1,32'h84,0,32'h0,32'h0,1));
    vq.push_back(mk(0,0,0,0,0,1,32'hBAD,
      1,32'h84,0,32'h0,32'h0,0));
    vq.push_back(mk(1,0,0,0,0,1,32'hD0,
      1,32'h300,1,32'hD0,32'h304,0));
    vq.push_back(mk(1,1,32'h400,0,0,0,32'h0,
      0,32'h304,0,32'h0,32'h0,1));
    vq.push_back(mk(0,0,0,0,0,1,32'hD1,
      1,32'h400,1,32'hD1,32'h404,0));
    vq.push_back(mk(0,0,0,1,32'h500,0,32'h0,
      1,32'h404,0,32'h0,32'h0,1));
    vq.push_back(mk(0,1,32'h600,0,0,1,32'hBAD,
      1,32'h404,0,32'h0,32'h0,1));
    vq.push_back(mk(0,0,0,0,0,1,32'hE0,
      1,32'h600,1,32'hE0,32'h604,0));

    for (int i = 0; i < vq.size(); i++) begin
      string t;
      t = $sformatf("v%0d", i);
      freeze        = vq[i].frz;
      branch_taken  = vq[i].br;
      branch_target = vq[i].bt;
      jump          = vq[i].jp;
      jump_target   = vq[i].jt;
      imem_ready    = vq[i].rdy;
      imem_rdata    = vq[i].rd;
      #3;
      chk({t, "_req"}, 32'(imem_req),
          32'(vq[i].ereq));
      chk({t, "_addr"}, imem_addr,
          vq[i].eaddr);
      chk({t, "_valid"}, 32'(if_valid),
          32'(vq[i].evalid));
      chk({t, "_instr"}, instruction,
          vq[i].einstr);
      chk({t, "_pc4"}, pc_plus_4,
          vq[i].epc4);
      chk({t, "_flush"}, 32'(IF_Flush),
          32'(vq[i].eflush));
      chk({t, "_err"}, 32'(fetch_error), 0);
      if (i == 0) begin
        chk("wrap_pc4", w_pc4, 32'h0);
        chk("wrap_valid", 32'(w_valid), 1);
      end
      if (i == 1)
        chk("wrap_addr", w_addr, 32'h0);
      tick();
    end

    idle();
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (k == 14)
        chk("to_err14", 32'(fetch_error), 0);
    end
    chk("to_err15", 32'(fetch_error), 1);
    chk("to_addr", imem_addr, 32'h604);
    chk("to_req", 32'(imem_req), 1);

    imem_ready = 1;
    imem_rdata = 32'h77;
    #3;
    chk("to_late_valid", 32'(if_valid), 1);
    chk("to_late_instr", instruction, 32'h77);
    tick();
    tick();
    chk("to_sticky", 32'(fetch_error), 1);

    freeze = 1;
    tick();
    chk("hold_req", 32'(imem_req), 0);
    reset = 1;
    imem_rdata = 32'hFACE;
    tick();
    reset = 0;
    freeze = 0;
    imem_ready = 0;
    #3;
    chk("rr_err", 32'(fetch_error), 0);
    chk("rr_addr", imem_addr, 0);
    chk("rr_req", 32'(imem_req), 1);
    chk("rr_valid", 32'(if_valid), 0);
    chk("rr_instr", instruction, 0);
    tick();
    imem_ready = 1;
    imem_rdata = 32'h1234;
    #3;
    chk("rr_f_instr", instruction, 32'h1234);
    chk("rr_f_pc4", pc_plus_4, 32'h4);
    tick();
    chk("rr_next", imem_addr, 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
IF_FETCH_STAGE -- requirements
Module: if_fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC loaded on reset.
REQ-002 SHALL have parameter MAX_WAIT, default 15, meaning the consecutive imem wait cycles that set fetch_error.
REQ-003 SHALL have port clk  in  1  single clock, all state updates on posedge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port freeze  in  1  hazard stall; the IF/ID register is not loading this cycle.
REQ-006 SHALL have port branch_taken  in  1  taken-branch redirect from ID.
REQ-007 SHALL have port branch_target  in  32  branch destination.
REQ-008 SHALL have port jump  in  1  jump redirect from ID.
REQ-009 SHALL have port jump_target  in  32  jump destination.
REQ-010 SHALL have port imem_ready  in  1  instruction memory data valid / request accepted.
REQ-011 SHALL have port imem_rdata  in  32  instruction word.
REQ-012 SHALL have port imem_req  out  1  fetch request.
REQ-013 SHALL have port imem_addr  out  32  fetch address.
REQ-014 SHALL have port instruction  out  32  word to IF/ID; 32'd0 (NOP) when if_valid=0.
REQ-015 SHALL have port pc_plus_4  out  32  fetched PC+4 to IF/ID; 0 when if_valid=0.
REQ-016 SHALL have port if_valid  out  1  instruction/pc_plus_4 carry a real fetch.
REQ-017 SHALL have port IF_Flush  out  1  flush to IF/ID.
REQ-018 SHALL have port fetch_error  out  1  sticky imem timeout flag.

Function
REQ-019 SHALL implement states FETCH, HOLD and DISCARD, with registers pc, tgt, hold_instr, hold_pc4, wait_cnt and fetch_error.
REQ-020 SHALL drive imem_req=1 and imem_addr=pc in FETCH and DISCARD, and imem_req=0 in HOLD; imem_addr SHALL be stable while imem_req=1 and imem_ready=0.
REQ-021 SHALL define redirect = jump | branch_taken and target = jump ? jump_target : branch_target, giving jump priority.
REQ-022 SHALL drive IF_Flush = redirect combinationally, in every state.
REQ-023 SHALL, in FETCH with imem_ready=1 and redirect=0, output instruction=imem_rdata, pc_plus_4=pc+4 and if_valid=1 in the same cycle, with zero latency.
REQ-024 SHALL, in FETCH with imem_ready=1, redirect=0 and freeze=0, set pc<=pc+4 and remain in FETCH so that back-to-back fetches occur, one per ready cycle.
REQ-025 SHALL, in FETCH with imem_ready=1, redirect=0 and freeze=1, set hold_instr<=imem_rdata, hold_pc4<=pc+4, pc<=pc+4, and go to HOLD.
REQ-026 SHALL, in FETCH with redirect=1 and imem_ready=1, discard the data with if_valid=0, set pc<=target, and remain in FETCH.
REQ-027 SHALL, in FETCH with redirect=1 and imem_ready=0, set tgt<=target, keep pc, and go to DISCARD.
REQ-028 SHALL, in HOLD, output hold_instr/hold_pc4 with if_valid=1; freeze=0 SHALL go to FETCH.
REQ-029 SHALL, in HOLD with redirect=1, take priority over freeze, set pc<=target, set if_valid=0, and go to FETCH.
REQ-030 SHALL, in DISCARD, hold if_valid=0; imem_ready=1 SHALL set pc<=tgt and go to FETCH.
REQ-031 SHALL, on redirect in DISCARD, let the latest target win: tgt<=target; if imem_ready=1 in the same cycle, pc<=target directly.
REQ-032 SHALL compute PC arithmetic modulo 2^32, so 32'hFFFF_FFFC+4 = 32'h0000_0000.
REQ-033 SHALL increment wait_cnt each cycle with imem_req=1 and imem_ready=0, saturating at MAX_WAIT, and clear it on imem_ready=1.
REQ-034 SHALL set fetch_error when wait_cnt reaches MAX_WAIT, hold it until reset, and keep waiting without aborting.

Reset
REQ-035 SHALL, on reset=1 at posedge, set state=FETCH, pc=RESET_PC, and tgt, hold_instr, hold_pc4, wait_cnt and fetch_error to 0.
REQ-036 SHALL assert imem_req=1 with imem_addr=RESET_PC in the first cycle after reset deasserts.
REQ-037 SHALL, on reset mid-DISCARD or mid-HOLD, abandon the outstanding or held data; imem data returning later is not used.

Structure
REQ-038 SHALL place the state enum, NOP constant (32'd0) and PC increment constant (4) in the shared pipeline package.
REQ-039 SHALL implement the wait counter and sticky error as sub-module if_wait_counter.

Verification
REQ-040 SHALL cover zero-wait streaming: ready=1 every cycle after reset -> imem_addr 0,4,8,12; pc_plus_4 4,8,12,16; if_valid=1 each cycle.
REQ-041 SHALL cover freeze: freeze=1 when word 0x2002000A returns at pc 8 -> HOLD, imem_req=0, instruction=0x2002000A, pc_plus_4=12 held; freeze=0 -> next request at addr 12.
REQ-042 SHALL cover redirect during wait: jump=1 with jump_target=0x40 while addr=0x10 and ready=0 -> IF_Flush=1, addr stays 0x10, if_valid=0 on its return; next request at 0x40.
REQ-043 SHALL cover simultaneous jump and branch: jump_target=0x80 and branch_target=0x100 -> next addr 0x80.
REQ-044 SHALL cover timeout: ready held 0 for 15 cycles -> fetch_error=1 and stays 1 after ready; reset clears it and restarts at RESET_PC.
REQ-045 SHALL cover wrap: RESET_PC=32'hFFFF_FFFC with ready=1 -> pc_plus_4=0, next imem_addr=0.
